fifo_status_arb: RTL and testbench
==================================

Name: fifo_status_arb

Overview:
- Multi-channel successor of the single-FIFO status controller.
- Monitors CH_NUM write-side FIFOs (fill count, empty flag, line/frame tail events).
- Issues one burst or tail request at a time to the shared AXI master, using round-robin arbitration.
- Sits between the per-channel stream FIFOs and the single VDMA AXI write engine; returns per-channel completion pulses.

Parameters:
- CH_NUM, 4, number of FIFO channels (1..16).
- CW, 10, width of each channel's fill count.
- LSIZE, 9, width of the request length.
- THRESHOLD, 200, a burst is eligible when count > THRESHOLD (strict).
- BURST_LEN, 100, req_len for normal bursts; must fit in LSIZE bits.
- MODE, "LINE", "LINE": line_tail arms the tail; "ONCE": frame_tail arms the tail.

Ports:
- clock, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- enable, in, 1, permits new grants.
- f_rst_status, in, 1, synchronous abort and clear.
- count, in, CH_NUM*CW, channel i fill count at [i*CW +: CW].
- fifo_empty, in, CH_NUM, per-channel empty flag.
- line_tail, in, CH_NUM, per-channel line-end pulse.
- frame_tail, in, CH_NUM, per-channel frame-end pulse.
- tail_len, in, CH_NUM*LSIZE, channel i residual length at [i*LSIZE +: LSIZE].
- req, out, 1, request valid.
- req_tail, out, 1, current request is a tail.
- req_ch, out, $clog2(CH_NUM) (min 1), granted channel.
- req_len, out, LSIZE, request length.
- resp, in, 1, master accepted the request.
- done, in, 1, master finished the transfer.
- burst_done, out, CH_NUM, one-cycle pulse per channel.
- tail_done, out, CH_NUM, one-cycle pulse per channel.
- tail_miss, out, CH_NUM, sticky flag: a tail event arrived while that channel's tail was already pending.
- busy, out, 1, FSM not in IDLE.

Behaviour:

Reset (rst_n low) and f_rst_status:
- All outputs 0, FSM IDLE, tail_pend 0, burst_exec 0, tail_miss 0, rr_ptr 0.
- f_rst_status acts at the next edge and has priority over every other event, including mid-transaction (REQ/WAIT_DONE abandoned, no done pulse).

Eligibility, per channel i:
- burst_exec[i] is registered from count[i] > THRESHOLD, so it lags count by 1 cycle.
- tail_pend[i] sets on line_tail[i] (LINE) or frame_tail[i] (ONCE).
- A tail event while tail_pend[i] is already 1 keeps it at 1 and sets tail_miss[i].
- In IDLE, if tail_pend[i] is set and count[i]==0 or tail_len[i]==0, tail_pend[i] clears silently: no request, no pulse.
- tail candidate: tail_pend[i] && !fifo_empty[i]. burst candidate: burst_exec[i] && !fifo_empty[i].
- A channel's tail candidate outranks its own burst candidate.

Arbitration:
- Round-robin search starts at rr_ptr+1 (mod CH_NUM); the first channel with any candidate wins.
- rr_ptr <= granted channel on entering FSH.

FSM states: IDLE, REQ, WAIT_DONE, FSH.
- IDLE -> REQ when enable && any candidate exists; otherwise stay.
- REQ -> WAIT_DONE when resp; otherwise stay.
- WAIT_DONE -> FSH when done; otherwise stay.
- FSH -> IDLE unconditionally.

Outputs (all registered from next-state):
- req = 1 while in REQ; it rises 1 cycle after the IDLE decision and falls on the edge after resp is sampled.
- req_ch, req_tail and req_len load on the IDLE->REQ transition and hold until the next grant.
- req_len = BURST_LEN for a burst, tail_len[ch] for a tail (sampled at grant).
- FSH: burst_done[req_ch] or tail_done[req_ch] is high for exactly 1 cycle; tail_pend[req_ch] clears there unless a new tail event arrives in that same cycle, in which case it stays set and no miss is flagged.
- resp outside REQ and done outside WAIT_DONE are ignored.
- Minimum cycle per transaction: 4 clocks (IDLE, REQ, WAIT_DONE, FSH) with resp and done each 1 cycle.
- enable low: no new grant; an in-flight transaction completes normally. Tail events are still latched.

Test Plan:
1. CH_NUM=4; count[2]=201, others 0; resp 2 cycles after req, done 5 cycles later -> req_ch=2, req_tail=0, req_len=100, then burst_done[2] 1-cycle pulse. With count[2]=200 -> no req.
2. count[0]=count[1]=count[3]=300 held; resp and done immediate; rr_ptr=0 -> grants in order 1, 3, 0, 1; each transaction is 4 cycles.
3. MODE="LINE": line_tail[1] pulse, count[1]=37, tail_len[1]=37, count[1] also >200 elsewhere irrelevant -> req_tail=1, req_len=37, tail_done[1] pulse, tail_pend cleared. Second line_tail[1] before completion -> tail_miss[1]=1 sticky.
4. line_tail[3] with count[3]=0 -> tail dropped, no req, no tail_done. MODE="ONCE": line_tail ignored; frame_tail[0] -> tail request on channel 0.
5. f_rst_status asserted in WAIT_DONE -> next edge: req=0, busy=0, no done pulse; a later done input is ignored; rr_ptr=0.
6. rst_n low asynchronously mid-REQ -> all outputs 0 immediately. enable=0 with count[0]=500 -> no req until enable=1, then req rises 2 cycles after enable (1-cycle lag plus registered req).

Source files
------------

// File: rtl/fifo_status_arb.sv
// Purpose: round-robin arbiter that turns per-channel FIFO fill/tail status into burst or tail requests for one shared AXI write master.
// Latency: a request is raised one clock after the IDLE grant decision; burst eligibility lags count by one more clock; minimum 4 clocks per transaction.
// Backpressure: the request is held until resp, then completion waits for done; enable low blocks new grants but tail events are still latched.
//
// Ports:
//   clock, rst_n           - clock, asynchronous active-low reset
//   enable, f_rst_status   - grant permit, synchronous abort/clear
//   count, fifo_empty      - per-channel fill count (CW bits each) and empty flag
//   line_tail, frame_tail  - per-channel tail event pulses (MODE picks which arms a tail)
//   tail_len               - per-channel residual length (LSIZE bits each)
//   req, req_tail, req_ch, req_len - request to the master
//   resp, done             - master accepted / finished
//   burst_done, tail_done  - one-cycle completion pulses per channel
//   tail_miss              - sticky: tail event arrived while that channel's tail was pending
//   busy                   - FSM not idle
module fifo_status_arb #(
    parameter int    CH_NUM    = 4,
    parameter int    CW        = 10,
    parameter int    LSIZE     = 9,
    parameter int    THRESHOLD = 200,
    parameter int    BURST_LEN = 100,
    parameter string MODE      = "LINE",
    localparam int   CHW       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    f_rst_status,
    input  logic [CH_NUM*CW-1:0]    count,
    input  logic [CH_NUM-1:0]       fifo_empty,
    input  logic [CH_NUM-1:0]       line_tail,
    input  logic [CH_NUM-1:0]       frame_tail,
    input  logic [CH_NUM*LSIZE-1:0] tail_len,
    output logic                    req,
    output logic                    req_tail,
    output logic [CHW-1:0]          req_ch,
    output logic [LSIZE-1:0]        req_len,
    input  logic                    resp,
    input  logic                    done,
    output logic [CH_NUM-1:0]       burst_done,
    output logic [CH_NUM-1:0]       tail_done,
    output logic [CH_NUM-1:0]       tail_miss,
    output logic                    busy
);

    localparam bit LINE_MODE = (MODE == "LINE");

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_DONE,
        S_FSH
    } state_t;

    state_t state, state_nxt;

    logic [CH_NUM-1:0] tail_pend, tail_pend_nxt;
    logic [CH_NUM-1:0] burst_exec;
    logic [CH_NUM-1:0] miss_set;
    logic [CH_NUM-1:0] tail_ev;
    logic [CH_NUM-1:0] over_thr, cnt_zero, len_zero;
    logic [CH_NUM-1:0] drop, tail_cand, burst_cand, any_cand;
    logic [CH_NUM-1:0] req_onehot;
    logic [LSIZE-1:0]  tl_arr [CH_NUM];
    logic [CHW-1:0]    rr_ptr;
    logic [CHW-1:0]    gnt_ch;
    logic [CHW-1:0]    idx_c;
    logic              gnt_vld, gnt_tail;
    logic              fsh_tail;

    assign tail_ev = LINE_MODE ? line_tail : frame_tail;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        assign tl_arr[g]   = tail_len[g*LSIZE +: LSIZE];
        assign cnt_zero[g] = (count[g*CW +: CW] == '0);
        assign len_zero[g] = (tail_len[g*LSIZE +: LSIZE] == '0);
        assign over_thr[g] = (32'(count[g*CW +: CW]) > THRESHOLD);
    end

    // A pending tail with nothing left to move is retired without a request;
    // it is masked out of the candidate set in the same cycle so it cannot win.
    assign drop       = tail_pend & (cnt_zero | len_zero);
    assign tail_cand  = tail_pend & ~fifo_empty & ~drop;
    assign burst_cand = burst_exec & ~fifo_empty;
    assign any_cand   = tail_cand | burst_cand;

    assign req_onehot = CH_NUM'(1) << req_ch;
    assign fsh_tail   = (state == S_FSH) && req_tail;
    assign busy       = (state != S_IDLE);

    // Round-robin: search starts one past the last completed channel.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_ch   = '0;
        gnt_tail = 1'b0;
        idx_c    = '0;
        for (int k = 1; k <= CH_NUM; k++) begin
            idx_c = CHW'((int'(rr_ptr) + k) % CH_NUM);
            if (!gnt_vld && any_cand[idx_c]) begin
                gnt_vld  = 1'b1;
                gnt_ch   = idx_c;
                gnt_tail = tail_cand[idx_c];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (enable && gnt_vld) state_nxt = S_REQ;
            S_REQ:       if (resp)              state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (done)              state_nxt = S_FSH;
            S_FSH:                              state_nxt = S_IDLE;
            default:                            state_nxt = S_IDLE;
        endcase
        if (f_rst_status) state_nxt = S_IDLE;
    end

    // Tail bookkeeping. A fresh event landing in the FSH cycle of this
    // channel's own tail re-arms it instead of counting as a miss.
    always_comb begin
        tail_pend_nxt = tail_pend;
        miss_set      = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if ((state == S_IDLE) && drop[i]) tail_pend_nxt[i] = 1'b0;
            if (fsh_tail && req_onehot[i])    tail_pend_nxt[i] = 1'b0;
            if (tail_ev[i]) begin
                tail_pend_nxt[i] = 1'b1;
                if (tail_pend[i] && !(fsh_tail && req_onehot[i])) miss_set[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tail_pend  <= '0;
            burst_exec <= '0;
            tail_miss  <= '0;
            rr_ptr     <= '0;
            req        <= 1'b0;
            req_tail   <= 1'b0;
            req_ch     <= '0;
            req_len    <= '0;
            burst_done <= '0;
            tail_done  <= '0;
        end else if (f_rst_status) begin
            state      <= S_IDLE;
            tail_pend  <= '0;
            burst_exec <= '0;
            tail_miss  <= '0;
            rr_ptr     <= '0;
            req        <= 1'b0;
            req_tail   <= 1'b0;
            req_ch     <= '0;
            req_len    <= '0;
            burst_done <= '0;
            tail_done  <= '0;
        end else begin
            state      <= state_nxt;
            tail_pend  <= tail_pend_nxt;
            burst_exec <= over_thr;
            tail_miss  <= tail_miss | miss_set;
            req        <= (state_nxt == S_REQ);
            burst_done <= '0;
            tail_done  <= '0;
            if ((state == S_IDLE) && (state_nxt == S_REQ)) begin
                req_ch   <= gnt_ch;
                req_tail <= gnt_tail;
                req_len  <= gnt_tail ? tl_arr[gnt_ch] : LSIZE'(BURST_LEN);
            end
            if ((state == S_WAIT_DONE) && (state_nxt == S_FSH)) begin
                rr_ptr <= req_ch;
                if (req_tail) tail_done  <= req_onehot;
                else          burst_done <= req_onehot;
            end
        end
    end

endmodule

// File: tb/tb_fifo_status_arb.sv
// Purpose: scoreboard bench for fifo_status_arb (LINE instance checked by a monitor, ONCE instance checked inline).
// Latency: expectations are queued at stimulus time and popped when the DUT raises req or a completion pulse.
// Backpressure: the master side (resp/done) is driven by the stimulus thread with programmable delays.
module tb_fifo_status_arb;
    localparam int CH = 4;
    localparam int CW = 10;
    localparam int LS = 9;

    logic             clock = 1'b0;
    logic             rst_n;
    logic             enable, f_rst_status;
    logic [CH*CW-1:0] count;
    logic [CH-1:0]    fifo_empty, line_tail;
    logic [CH*LS-1:0] tail_len;
    logic             resp, done;
    logic             req, req_tail, busy;
    logic [1:0]       req_ch;
    logic [LS-1:0]    req_len;
    logic [CH-1:0]    burst_done, tail_done, tail_miss;

    logic             o_enable, o_resp, o_done;
    logic [CH-1:0]    o_line, o_frame;
    logic             o_req, o_req_tail, o_busy;
    logic [1:0]       o_req_ch;
    logic [LS-1:0]    o_req_len;
    logic [CH-1:0]    o_burst_done, o_tail_done, o_tail_miss;

    int total;
    int bad;
    int cyc;
    int rise_gap;

    typedef struct {
        int ch;
        int tail;
        int len;
    } exp_req_t;

    exp_req_t   exp_req_q[$];
    logic [7:0] exp_done_q[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    fifo_status_arb #(.CH_NUM(CH), .CW(CW), .LSIZE(LS), .THRESHOLD(200), .BURST_LEN(100), .MODE("LINE")) dut (
        .clock(clock), .rst_n(rst_n), .enable(enable), .f_rst_status(f_rst_status),
        .count(count), .fifo_empty(fifo_empty), .line_tail(line_tail), .frame_tail(o_frame),
        .tail_len(tail_len), .req(req), .req_tail(req_tail), .req_ch(req_ch), .req_len(req_len),
        .resp(resp), .done(done), .burst_done(burst_done), .tail_done(tail_done),
        .tail_miss(tail_miss), .busy(busy)
    );

    fifo_status_arb #(.CH_NUM(CH), .CW(CW), .LSIZE(LS), .THRESHOLD(200), .BURST_LEN(100), .MODE("ONCE")) dut_once (
        .clock(clock), .rst_n(rst_n), .enable(o_enable), .f_rst_status(f_rst_status),
        .count(count), .fifo_empty(fifo_empty), .line_tail(o_line), .frame_tail(o_frame),
        .tail_len(tail_len), .req(o_req), .req_tail(o_req_tail), .req_ch(o_req_ch), .req_len(o_req_len),
        .resp(o_resp), .done(o_done), .burst_done(o_burst_done), .tail_done(o_tail_done),
        .tail_miss(o_tail_miss), .busy(o_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_req(input int ch, input int tail, input int len);
        exp_req_t e;
        e.ch   = ch;
        e.tail = tail;
        e.len  = len;
        exp_req_q.push_back(e);
    endtask

    task automatic push_done(input logic [7:0] v);
        exp_done_q.push_back(v);
    endtask

    task automatic set_cnt(input int ch, input int v);
        count[ch*CW +: CW] = v[CW-1:0];
    endtask

    task automatic set_len(input int ch, input int v);
        tail_len[ch*LS +: LS] = v[LS-1:0];
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_req();
        int k;
        k = 0;
        while (req !== 1'b1 && k < 100) begin
            @(negedge clock);
            k++;
        end
        chk("req_seen", 32'(req), 1);
    endtask

    // Plays the AXI master: resp rdly cycles after req, done ddly cycles after
    // resp. mid_ev pulses line_tail in WAIT_DONE, fsh_ev pulses it in FSH.
    task automatic serve(input int rdly, input int ddly, input logic [3:0] mid_ev, input logic [3:0] fsh_ev);
        wait_req();
        if (req !== 1'b1) return;
        repeat (rdly) @(negedge clock);
        resp = 1'b1;
        @(negedge clock);
        resp = 1'b0;
        line_tail = mid_ev;
        repeat (ddly) begin
            @(negedge clock);
            line_tail = '0;
        end
        line_tail = '0;
        done = 1'b1;
        @(negedge clock);
        done = 1'b0;
        line_tail = fsh_ev;
        if (fsh_ev != '0) begin
            @(negedge clock);
            line_tail = '0;
        end
    endtask

    // Monitor: compares each new request and each completion pulse against the queues.
    initial begin
        exp_req_t   e;
        logic [7:0] d;
        logic       req_prev;
        int         last_rise;
        req_prev  = 1'b0;
        last_rise = 0;
        forever begin
            @(negedge clock);
            if (rst_n && req && !req_prev) begin
                rise_gap  = cyc - last_rise;
                last_rise = cyc;
                if (exp_req_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_req: got ch=%0d tail=%0d len=%0d, want no request", req_ch, req_tail, req_len);
                end else begin
                    e = exp_req_q.pop_front();
                    chk("req_ch", 32'(req_ch), e.ch);
                    chk("req_tail", 32'(req_tail), e.tail);
                    chk("req_len", 32'(req_len), e.len);
                end
            end
            req_prev = req;
            if ((burst_done | tail_done) != '0) begin
                if (exp_done_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got tail_done=%b burst_done=%b, want none", tail_done, burst_done);
                end else begin
                    d = exp_done_q.pop_front();
                    chk("done_pulse", 32'({tail_done, burst_done}), 32'(d));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        total = 0; bad = 0; cyc = 0; rise_gap = 0;
        rst_n = 1'b0; enable = 1'b0; f_rst_status = 1'b0;
        count = '0; fifo_empty = '0; line_tail = '0; tail_len = '0;
        resp = 1'b0; done = 1'b0;
        o_enable = 1'b0; o_resp = 1'b0; o_done = 1'b0; o_line = '0; o_frame = '0;
        wait_cyc(2);

        // Reset state
        chk("rst_req", 32'(req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_meta", 32'({req_tail, req_ch, req_len}), 0);
        chk("rst_flags", 32'({burst_done, tail_done, tail_miss}), 0);
        rst_n = 1'b1;
        enable = 1'b1;
        @(negedge clock);

        // Single burst on channel 2, then count==THRESHOLD must not qualify
        push_req(2, 0, 100);
        push_done(8'h04);
        set_cnt(2, 201);
        serve(2, 5, 4'b0000, 4'b0000);
        set_cnt(2, 200);
        wait_cyc(10);
        chk("t1_eq_thr_no_req", 32'(req), 0);
        set_cnt(2, 0);

        // Round-robin from rr_ptr=0 over channels 0,1,3
        f_rst_status = 1'b1;
        @(negedge clock);
        f_rst_status = 1'b0;
        wait_cyc(2);
        push_req(1, 0, 100); push_req(3, 0, 100); push_req(0, 0, 100); push_req(1, 0, 100);
        push_done(8'h02); push_done(8'h08); push_done(8'h01); push_done(8'h02);
        set_cnt(0, 300); set_cnt(1, 300); set_cnt(3, 300);
        serve(0, 0, 4'b0000, 4'b0000);
        for (int n = 0; n < 3; n++) begin
            serve(0, 0, 4'b0000, 4'b0000);
            chk("t2_gap", 32'(rise_gap), 4);
        end
        set_cnt(0, 0); set_cnt(1, 0); set_cnt(3, 0);
        wait_cyc(6);
        chk("t2_idle", 32'(busy), 0);

        // Line tail on channel 1, second event mid-transaction -> sticky miss
        set_len(1, 37);
        set_cnt(1, 37);
        push_req(1, 1, 37);
        push_done(8'h20);
        line_tail = 4'b0010;
        @(negedge clock);
        line_tail = '0;
        serve(0, 2, 4'b0010, 4'b0000);
        wait_cyc(10);
        chk("t3_no_retail", 32'(req), 0);
        chk("t3_miss", 32'(tail_miss), 32'h2);
        set_cnt(1, 0);

        // Tail event during FSH re-arms channel 2 without a miss
        set_len(2, 15);
        set_cnt(2, 20);
        push_req(2, 1, 15); push_req(2, 1, 15);
        push_done(8'h40); push_done(8'h40);
        line_tail = 4'b0100;
        @(negedge clock);
        line_tail = '0;
        serve(0, 1, 4'b0000, 4'b0100);
        serve(0, 0, 4'b0000, 4'b0000);
        wait_cyc(8);
        chk("t3b_req", 32'(req), 0);
        chk("t3b_no_miss", 32'(tail_miss), 32'h2);
        set_cnt(2, 0);

        // Silent drops: count==0 on ch3, tail_len==0 on ch0; stray resp/done in IDLE
        set_len(3, 22);
        set_cnt(3, 0);
        line_tail = 4'b1000;
        @(negedge clock);
        line_tail = '0;
        wait_cyc(4);
        set_cnt(3, 50);
        set_len(0, 0);
        set_cnt(0, 40);
        line_tail = 4'b0001;
        @(negedge clock);
        line_tail = '0;
        wait_cyc(4);
        set_len(0, 12);
        resp = 1'b1; done = 1'b1;
        @(negedge clock);
        resp = 1'b0; done = 1'b0;
        wait_cyc(8);
        chk("t4_drop_req", 32'(req), 0);
        chk("t4_drop_busy", 32'(busy), 0);
        chk("t4_miss", 32'(tail_miss), 32'h2);
        set_cnt(3, 0);

        // fifo_empty blocks a burst candidate until it clears
        fifo_empty = 4'b0100;
        set_cnt(2, 300);
        wait_cyc(8);
        chk("t4_empty_blocks", 32'(req), 0);
        push_req(2, 0, 100);
        push_done(8'h04);
        fifo_empty = '0;
        serve(0, 0, 4'b0000, 4'b0000);
        set_cnt(2, 0);
        wait_cyc(4);

        // ONCE instance: line_tail ignored, frame_tail arms channel 0 (count 40, len 12)
        o_enable = 1'b1;
        o_line = 4'b0001;
        @(negedge clock);
        o_line = '0;
        wait_cyc(6);
        chk("once_line_ignored", 32'(o_req), 0);
        o_frame = 4'b0001;
        @(negedge clock);
        o_frame = '0;
        k = 0;
        while (o_req !== 1'b1 && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("once_req", 32'(o_req), 1);
        chk("once_ch", 32'(o_req_ch), 0);
        chk("once_tail", 32'(o_req_tail), 1);
        chk("once_len", 32'(o_req_len), 12);
        o_resp = 1'b1;
        @(negedge clock);
        o_resp = 1'b0;
        o_done = 1'b1;
        @(negedge clock);
        o_done = 1'b0;
        chk("once_tail_done", 32'({o_tail_done, o_burst_done}), 32'h10);
        @(negedge clock);
        chk("once_pulse_1cyc", 32'({o_tail_done, o_burst_done}), 0);
        o_enable = 1'b0;
        set_cnt(0, 0);
        wait_cyc(4);

        // Abort in WAIT_DONE: no pulse, late done ignored, rr_ptr back to 0
        push_req(0, 0, 100);
        set_cnt(0, 300);
        wait_req();
        resp = 1'b1;
        @(negedge clock);
        resp = 1'b0;
        f_rst_status = 1'b1;
        set_cnt(0, 0);
        @(negedge clock);
        f_rst_status = 1'b0;
        chk("t5_req", 32'(req), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_miss_clr", 32'(tail_miss), 0);
        done = 1'b1;
        @(negedge clock);
        done = 1'b0;
        wait_cyc(4);
        chk("t5_done_ignored", 32'(busy), 0);
        push_req(1, 0, 100);
        push_done(8'h02);
        set_cnt(1, 300); set_cnt(3, 300);
        serve(0, 0, 4'b0000, 4'b0000);
        set_cnt(1, 0); set_cnt(3, 0);
        wait_cyc(4);

        // Async reset mid-REQ, then enable gating and grant latency
        push_req(0, 0, 100);
        set_cnt(0, 500);
        wait_req();
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("t6_async_req", 32'(req), 0);
        chk("t6_async_busy", 32'(busy), 0);
        chk("t6_async_len", 32'(req_len), 0);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(8);
        chk("t6_en_low", 32'(req), 0);
        set_cnt(0, 0);
        wait_cyc(2);
        push_req(0, 0, 100);
        push_done(8'h01);
        enable = 1'b1;
        set_cnt(0, 500);
        @(negedge clock);
        chk("t6_lag1", 32'(req), 0);
        @(negedge clock);
        chk("t6_lag2", 32'(req), 1);
        serve(0, 0, 4'b0000, 4'b0000);
        set_cnt(0, 0);
        wait_cyc(6);

        chk("q_req_empty", 32'(exp_req_q.size()), 0);
        chk("q_done_empty", 32'(exp_done_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
